// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;

  localparam logic [3:0]  ONES_MAX  = 4'd9;
  localparam logic [3:0]  TENS_MAX  = 4'd5;
  localparam logic [15:0] TIME_MAX  = 16'h5959;
  localparam logic [15:0] TIME_ONE  = 16'h0001;
  localparam logic [15:0] TIME_ZERO = 16'h0000;

  // True when every digit of a packed {mt, mo, st, so} value is in range.
  function automatic logic bcd_time_valid(input logic [15:0] v);
    return (v[15:12] <= TENS_MAX) && (v[11:8] <= ONES_MAX) &&
           (v[7:4]   <= TENS_MAX) && (v[3:0]  <= ONES_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with clear/load/increment/decrement and ripple carry/borrow.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = ONES_MAX
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       inc_i,
  input  logic       dec_i,
  output logic [3:0] value_o,
  output logic       carry_o,
  output logic       borrow_o
);

  logic [3:0] value_q;
  logic [3:0] value_d;

  assign value_o  = value_q;
  assign carry_o  = inc_i && (value_q == MAX);
  assign borrow_o = dec_i && (value_q == '0);

  // Next digit value: clear beats load beats count.
  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (load_i) begin
      value_d = load_val_i;
    end else if (inc_i) begin
      value_d = (value_q == MAX) ? '0 : value_q + 4'd1;
    end else if (dec_i) begin
      value_d = (value_q == '0) ? MAX : value_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch / countdown controller with prescaled one-second tick.
// Optional lap-freeze display enabled by defining STOPWATCH_LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        up,
  input  logic        load_en,
  input  logic [15:0] load_val,
`ifdef STOPWATCH_LAP_EN
  input  logic        lap,
`endif
  output logic [15:0] digits,
  output logic        running,
  output logic        done
);

  localparam int unsigned    CW       = $clog2(TICK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

  sw_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_up_q, dir_up_d;

  logic [15:0]   live;
  logic          tick;
  logic          start_ok;
  logic          dig_clr;
  logic          dig_load;
  logic          inc_en;
  logic          dec_en;
  logic [3:0]    carry;
  logic [3:0]    borrow;

  assign tick     = (state_q == RUN) && (cnt_q == CNT_LAST);
  // A down-count from 00:00 would finish instantly, so that start is refused.
  assign start_ok = up || (live != TIME_ZERO);
  assign dig_clr  = clear;
  // Limits are decoded from the live value: at 59:59 the up-tick is swallowed
  // so the display holds instead of wrapping.
  assign inc_en   = tick && dir_up_q && (live != TIME_MAX);
  assign dec_en   = tick && !dir_up_q;

  // Command decode and state/prescaler/direction next-state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_up_d = dir_up_q;
    dig_load = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      cnt_d    = '0;
      dir_up_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (stop) begin
            state_d = IDLE;
          end else if (start && start_ok) begin
            dir_up_d = up;
            cnt_d    = '0;
            state_d  = RUN;
          end else if (load_en && bcd_time_valid(load_val)) begin
            dig_load = 1'b1;
          end
        end
        RUN: begin
          // Counting continues through a stop cycle; stop only parks the FSM.
          cnt_d = tick ? '0 : cnt_q + CW'(1);
          if (tick && dir_up_q && (live == TIME_MAX)) begin
            state_d = DONE;
          end else if (tick && !dir_up_q && (live == TIME_ONE)) begin
            state_d = DONE;
          end else if (stop) begin
            state_d = PAUSE;
          end
        end
        PAUSE: begin
          if (!stop && start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // FSM, prescaler and direction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dir_up_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_up_q <= dir_up_d;
    end
  end

  bcd_digit #(.MAX(ONES_MAX)) u_sec_ones (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (dig_clr),
    .load_i     (dig_load),
    .load_val_i (load_val[3:0]),
    .inc_i      (inc_en),
    .dec_i      (dec_en),
    .value_o    (live[3:0]),
    .carry_o    (carry[0]),
    .borrow_o   (borrow[0])
  );

  bcd_digit #(.MAX(TENS_MAX)) u_sec_tens (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (dig_clr),
    .load_i     (dig_load),
    .load_val_i (load_val[7:4]),
    .inc_i      (carry[0]),
    .dec_i      (borrow[0]),
    .value_o    (live[7:4]),
    .carry_o    (carry[1]),
    .borrow_o   (borrow[1])
  );

  bcd_digit #(.MAX(ONES_MAX)) u_min_ones (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (dig_clr),
    .load_i     (dig_load),
    .load_val_i (load_val[11:8]),
    .inc_i      (carry[1]),
    .dec_i      (borrow[1]),
    .value_o    (live[11:8]),
    .carry_o    (carry[2]),
    .borrow_o   (borrow[2])
  );

  bcd_digit #(.MAX(TENS_MAX)) u_min_tens (
    .clk_i      (clk),
    .rst_i      (reset),
    .clr_i      (dig_clr),
    .load_i     (dig_load),
    .load_val_i (load_val[15:12]),
    .inc_i      (carry[2]),
    .dec_i      (borrow[2]),
    .value_o    (live[15:12]),
    .carry_o    (carry[3]),
    .borrow_o   (borrow[3])
  );

  // The last stage's carry/borrow has no consumer.
  logic unused_chain;
  assign unused_chain = carry[3] | borrow[3];

  assign running = (state_q == RUN);
  assign done    = (state_q == DONE);

`ifdef STOPWATCH_LAP_EN
  logic        freeze_q, freeze_d;
  logic [15:0] lap_q, lap_d;

  // Lap toggles the frozen display in RUN; clear and reaching DONE release it.
  always_comb begin
    freeze_d = freeze_q;
    lap_d    = lap_q;
    if (clear) begin
      freeze_d = 1'b0;
    end else if ((state_q == RUN) && (state_d == DONE)) begin
      freeze_d = 1'b0;
    end else if ((state_q == RUN) && lap) begin
      freeze_d = !freeze_q;
      if (!freeze_q) begin
        lap_d = live;
      end
    end
  end

  // Lap snapshot and freeze flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      freeze_q <= 1'b0;
      lap_q    <= '0;
    end else begin
      freeze_q <= freeze_d;
      lap_q    <= lap_d;
    end
  end

  assign digits = freeze_q ? lap_q : live;
`else
  assign digits = live;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4.
module tb_stopwatch_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        clear;
  logic        up;
  logic        load_en;
  logic [15:0] load_val;
`ifdef STOPWATCH_LAP_EN
  logic        lap;
`endif
  logic [15:0] digits;
  logic        running;
  logic        done;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic        r;
    logic        dn;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  stopwatch_ctrl #(.TICK_DIV(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .up       (up),
    .load_en  (load_en),
    .load_val (load_val),
`ifdef STOPWATCH_LAP_EN
    .lap      (lap),
`endif
    .digits   (digits),
    .running  (running),
    .done     (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: compare every pending expectation on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (digits !== e.d || running !== e.r || done !== e.dn) begin
        failures++;
        $display("FAIL %s: got digits=%h running=%b done=%b, want digits=%h running=%b done=%b",
                 e.name, digits, running, done, e.d, e.r, e.dn);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic expect_st(input string nm, input logic [15:0] d, input logic r, input logic dn);
    exp_t e;
    e.name = nm;
    e.d    = d;
    e.r    = r;
    e.dn   = dn;
    sb.push_back(e);
  endtask

  task automatic cmd(input logic s, input logic st, input logic c, input logic l);
    start   = s;
    stop    = st;
    clear   = c;
    load_en = l;
    cyc(1);
    start   = 1'b0;
    stop    = 1'b0;
    clear   = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load_val = v;
    cmd(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
    up = 1'b0; load_en = 1'b0; load_val = '0;
`ifdef STOPWATCH_LAP_EN
    lap = 1'b0;
`endif
    cyc(1);
    expect_st("reset_state", 16'h0000, 1'b0, 1'b0);
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL reset_running: got running=%b", running);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got done=%b", done);
    end
    cyc(1);
    reset = 1'b0;

    // Up-count from zero, then asynchronous reset with a tick pending.
    up = 1'b1;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("t1_start", 16'h0000, 1'b1, 1'b0);
    cyc(3);
    expect_st("t1_pre_tick", 16'h0000, 1'b1, 1'b0);
    cyc(1);
    expect_st("t1_first_tick", 16'h0001, 1'b1, 1'b0);
    cyc(12);
    expect_st("t1_four_ticks", 16'h0004, 1'b1, 1'b0);
    cyc(3);
    reset = 1'b1;
    #2;
    expect_st("t1_async_reset", 16'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(5);
    expect_st("t1_no_pending_tick", 16'h0000, 1'b0, 1'b0);

    // Load, carry/borrow chains, invalid loads.
    do_load(16'h0059);
    expect_st("t2_load_0059", 16'h0059, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4);
    expect_st("t2_carry_to_min", 16'h0100, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("t2_clear", 16'h0000, 1'b0, 1'b0);
    do_load(16'h0060);
    expect_st("t2_load_tens_invalid", 16'h0000, 1'b0, 1'b0);
    do_load(16'h000A);
    expect_st("t2_load_ones_invalid", 16'h0000, 1'b0, 1'b0);
    do_load(16'h0959);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4);
    expect_st("t2_carry_to_min_tens", 16'h1000, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    do_load(16'h1000);
    up = 1'b0;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(4);
    expect_st("t2_borrow_chain", 16'h0959, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("t2_clear_again", 16'h0000, 1'b0, 1'b0);

    // Countdown to zero and DONE behaviour.
    do_load(16'h0002);
    up = 1'b0;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("t3_start_down", 16'h0002, 1'b1, 1'b0);
    cyc(4);
    expect_st("t3_one_tick", 16'h0001, 1'b1, 1'b0);
    cyc(4);
    expect_st("t3_done_at_zero", 16'h0000, 1'b0, 1'b1);
    up = 1'b1;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("t3_start_in_done", 16'h0000, 1'b0, 1'b1);
    do_load(16'h0030);
    expect_st("t3_load_in_done", 16'h0000, 1'b0, 1'b1);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
    expect_st("t3_clear_done", 16'h0000, 1'b0, 1'b0);
    up = 1'b0;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("t3_down_from_zero", 16'h0000, 1'b0, 1'b0);

    // Pause preserves the prescaler phase.
    up = 1'b1;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(5);
    cmd(1'b0, 1'b1, 1'b0, 1'b0);
    expect_st("t4_paused", 16'h0001, 1'b0, 1'b0);
    cyc(20);
    expect_st("t4_pause_hold", 16'h0001, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("t4_resume", 16'h0001, 1'b1, 1'b0);
    cyc(1);
    expect_st("t4_resume_plus1", 16'h0001, 1'b1, 1'b0);
    cyc(1);
    expect_st("t4_resume_plus2", 16'h0002, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);

    // Up-count limit and clear priority.
    do_load(16'h5958);
    up = 1'b1;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    expect_st("t5_start", 16'h5958, 1'b1, 1'b0);
    cyc(4);
    expect_st("t5_at_max", 16'h5959, 1'b1, 1'b0);
    cyc(4);
    expect_st("t5_done_hold", 16'h5959, 1'b0, 1'b1);
    cyc(4);
    expect_st("t5_still_held", 16'h5959, 1'b0, 1'b1);
    cmd(1'b1, 1'b0, 1'b1, 1'b0);
    expect_st("t5_clear_wins", 16'h0000, 1'b0, 1'b0);

`ifdef STOPWATCH_LAP_EN
    // Lap freeze while counting continues underneath.
    up = 1'b1;
    cmd(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(12);
    expect_st("t6_before_lap", 16'h0003, 1'b1, 1'b0);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    expect_st("t6_lap_frozen", 16'h0003, 1'b1, 1'b0);
    cyc(11);
    expect_st("t6_frozen_3_ticks", 16'h0003, 1'b1, 1'b0);
    lap = 1'b1;
    cyc(1);
    lap = 1'b0;
    expect_st("t6_lap_release", 16'h0006, 1'b1, 1'b0);
    cmd(1'b0, 1'b0, 1'b1, 1'b0);
`endif

    cyc(2);
    checks++;
    if (digits !== 16'h0000) begin
      failures++;
      $display("FAIL final_digits: got digits=%h", digits);
    end
    checks++;
    if (running !== 1'b0) begin
      failures++;
      $display("FAIL final_running: got running=%b", running);
    end
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL final_done: got done=%b", done);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000000, clock cycles per one-second tick (>=2).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  single-cycle pulse: start or resume counting.
REQ-005 SHALL have port stop  input  1  single-cycle pulse: pause counting.
REQ-006 SHALL have port clear  input  1  single-cycle pulse: abort and return to 00:00.
REQ-007 SHALL have port up  input  1  direction, 1=count up, 0=count down; sampled only when start is accepted in IDLE.
REQ-008 SHALL have port load_en  input  1  loads load_val into the digits; accepted in IDLE only.
REQ-009 SHALL have port load_val  input  16  BCD {min_tens, min_ones, sec_tens, sec_ones}, 4 bits each.
REQ-010 SHALL have port digits  output  16  displayed BCD value, same packing as load_val.
REQ-011 SHALL have port running  output  1  high while state is RUN.
REQ-012 SHALL have port done  output  1  high while state is DONE.

Function
REQ-013 SHALL implement an FSM with states IDLE, RUN, PAUSE and DONE.
REQ-014 SHALL apply command priority clear > stop > start > load_en when several are asserted in the same cycle.
REQ-015 SHALL, on clear in any state, enter IDLE next cycle with digits 00:00, prescaler 0 and direction up.
REQ-016 SHALL, in IDLE on start, latch up into a direction register and enter RUN, except with up=0 and value 00:00, where start is ignored.
REQ-017 SHALL, in IDLE on load_en, load load_val only if every ones digit <=9 and every tens digit <=5; an invalid value leaves the digits unchanged.
REQ-018 SHALL move RUN to PAUSE on stop, and PAUSE to RUN on start; the direction and prescaler count are preserved.
REQ-019 SHALL ignore start, stop and load_en in DONE; only clear leaves DONE.
REQ-020 SHALL run the prescaler from 0 to TICK_DIV-1 in RUN only, with a tick in the cycle where count==TICK_DIV-1, wrapping to 0.
REQ-021 SHALL reset the prescaler to 0 on the IDLE->RUN transition.
REQ-022 SHALL, on a tick counting up, increment sec_ones with wrap and carry: ones 9->0, tens 5->0, chained sec->min.
REQ-023 SHALL, on a tick counting down, decrement with borrow: ones 0->9, tens 0->5, chained sec->min.
REQ-024 SHALL make every digit update take effect on the edge after the tick cycle (latency 1).
REQ-025 SHALL, counting up, enter DONE and hold 59:59 (no wrap to 00:00) when a tick arrives at 59:59.
REQ-026 SHALL, counting down, update to 00:00 and enter DONE on the same edge when a tick arrives at 00:01.
REQ-027 SHALL make running and done pure decodes of the state register.

Reset
REQ-028 SHALL, on reset assertion and independent of clk, set state IDLE, digits 00:00, prescaler 0, direction up, running 0 and done 0.
REQ-029 SHALL abort counting immediately on reset mid-RUN, with no pending tick applied after reset release.

Configuration
REQ-030 SHALL, with macro STOPWATCH_LAP_EN defined, add port lap (input, 1) and a 16-bit lap register.
REQ-031 SHALL, with the macro defined, toggle a freeze flag on a lap pulse in RUN only; setting it snapshots the live value.
REQ-032 SHALL, with the macro defined, drive digits from the snapshot while frozen; counting continues internally.
REQ-033 SHALL, with the macro defined, release freeze on clear, on entry to DONE and on reset.
REQ-034 SHALL, without the macro, have no lap port and always show the live digits.

Structure
REQ-035 SHALL place the state enum (IDLE/RUN/PAUSE/DONE) and the constants ONES_MAX=9 and TENS_MAX=5 in package stopwatch_pkg.
REQ-036 SHALL use one sub-module, bcd_digit: one digit with inc/dec/load, parameterised max, giving carry/borrow out; instantiated four times.

Verification (TICK_DIV=4)
REQ-037 SHALL cover: reset, up=1, start, 4 ticks (16 cycles) -> digits 00:04, running=1.
REQ-038 SHALL cover: load 00:59 then start up; after 1 tick -> 01:00. Load 00:60 -> ignored, digits stay 00:00.
REQ-039 SHALL cover: load 00:02, up=0, start; 2 ticks -> 00:00, done=1; later start ignored; clear -> IDLE, done=0.
REQ-040 SHALL cover: start, stop after 6 cycles, idle 20 cycles (digits frozen), start -> next tick after exactly 2 more cycles.
REQ-041 SHALL cover: load 59:58 counting up; 2 ticks -> 59:59 and DONE, digits held; start and clear in the same cycle -> clear wins.
REQ-042 SHALL cover, with STOPWATCH_LAP_EN: lap at 00:03 -> digits stay 00:03 for 3 ticks; lap again -> digits show 00:06.
